// File: rtl/module_barrido_teclado.sv
// -----------------------------------------------------------------------------
// module_barrido_teclado
// Row-scan driver for a 4x4 matrix keypad. One active-low row line is driven at
// a time; the active-low column lines are synchronised and evaluated once per
// sample tick. A single pressed key is captured, debounced on press and on
// release, and encoded into the 4-bit key map below.
//
// Ports:
//   clk       in   1  system clock (only clock)
//   rst       in   1  asynchronous, active-low reset
//   column    in   4  keypad columns, active-low, pulled up when idle
//   row       out  4  keypad row drive, active-low one-hot
//   key_code  out  4  code of the last accepted key
//   key_valid out  1  one-clock pulse per accepted key
//   key_held  out  1  high while the accepted key remains pressed
//
// Optional feature macro: AUTO_REPEAT_EN
//   When defined, a key kept down in HELD re-pulses key_valid after
//   REPEAT_DELAY sample ticks and then every REPEAT_RATE sample ticks.
//
// Key map (row 1110/1101/1011/0111 x column 1110/1101/1011/0111):
//   r0: 1  2  3 10
//   r1: 4  5  6 11
//   r2: 7  8  9 12
//   r3: 14 0 15 13
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module module_barrido_teclado #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 10,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] column,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [DEB_W-1:0]  DEB_ZERO  = DEB_W'(0);

    // Elaboration-time guard on the configuration range.
    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("module_barrido_teclado: parameter out of range");
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_L = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_RATE_L  = REP_W'(REPEAT_RATE);
    localparam logic [REP_W-1:0] REP_ONE     = REP_W'(1);
    localparam logic [REP_W-1:0] REP_ZERO    = REP_W'(0);
`endif

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // ---------------------------------------------------------------- helpers
    // True when exactly one bit of an active-low pattern is low.
    function automatic logic one_low(input logic [3:0] v);
        logic r;
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // Position of the low bit in a one-hot-low pattern.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] r;
        case (v)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Next row in the scan order 1110 -> 1101 -> 1011 -> 0111 -> 1110.
    function automatic logic [3:0] rotate_row(input logic [3:0] r);
        return {r[2:0], r[3]};
    endfunction

    function automatic logic [3:0] map_key(input logic [3:0] r, input logic [3:0] c);
        logic [3:0] k;
        case ({low_index(r), low_index(c)})
            4'h0: k = 4'd1;   4'h1: k = 4'd2;   4'h2: k = 4'd3;   4'h3: k = 4'd10;
            4'h4: k = 4'd4;   4'h5: k = 4'd5;   4'h6: k = 4'd6;   4'h7: k = 4'd11;
            4'h8: k = 4'd7;   4'h9: k = 4'd8;   4'hA: k = 4'd9;   4'hB: k = 4'd12;
            4'hC: k = 4'd14;  4'hD: k = 4'd0;   4'hE: k = 4'd15;  4'hF: k = 4'd13;
            default: k = 4'd0;
        endcase
        return k;
    endfunction

    // ---------------------------------------------------------------- state
    state_t             state_r, state_nxt;
    logic [TICK_W-1:0]  tick_cnt_r;
    logic [3:0]         col_meta_r, col_s_r;
    logic [3:0]         row_r, row_nxt;
    logic [3:0]         cap_col_r, cap_col_nxt;
    logic [DEB_W-1:0]   deb_cnt_r, deb_cnt_nxt;
    logic [DEB_W-1:0]   rel_cnt_r, rel_cnt_nxt;
    logic [3:0]         key_code_r, key_code_nxt;
    logic               key_valid_r, key_valid_nxt;
    logic               key_held_r, key_held_nxt;
    logic               tick_s;
    logic [DEB_W-1:0]   deb_inc_s, rel_inc_s;
`ifdef AUTO_REPEAT_EN
    logic [REP_W-1:0]   rep_cnt_r, rep_cnt_nxt, rep_inc_s;
    logic               rep_armed_r, rep_armed_nxt;
`endif

    assign tick_s    = (tick_cnt_r == TICK_LAST);
    assign deb_inc_s = deb_cnt_r + DEB_ONE;
    assign rel_inc_s = rel_cnt_r + DEB_ONE;
`ifdef AUTO_REPEAT_EN
    assign rep_inc_s = rep_cnt_r + REP_ONE;
`endif

    assign row       = row_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

    // Next-state and output decode; every decision is taken on a sample tick.
    always_comb begin
        state_nxt     = state_r;
        row_nxt       = row_r;
        cap_col_nxt   = cap_col_r;
        deb_cnt_nxt   = deb_cnt_r;
        rel_cnt_nxt   = rel_cnt_r;
        key_code_nxt  = key_code_r;
        key_valid_nxt = 1'b0;
        key_held_nxt  = key_held_r;
`ifdef AUTO_REPEAT_EN
        rep_cnt_nxt   = rep_cnt_r;
        rep_armed_nxt = rep_armed_r;
`endif
        case (state_r)
            SCAN: begin
                if (tick_s) begin
                    if (one_low(col_s_r)) begin
                        // Row stays frozen on the captured row from here on.
                        cap_col_nxt = col_s_r;
                        if (DEB_ONE == DEB_LAST) begin
                            key_code_nxt  = map_key(row_r, col_s_r);
                            key_valid_nxt = 1'b1;
                            key_held_nxt  = 1'b1;
                            deb_cnt_nxt   = DEB_ZERO;
                            state_nxt     = HELD;
                        end else begin
                            deb_cnt_nxt = DEB_ONE;
                            state_nxt   = DEBOUNCE;
                        end
                    end else begin
                        // No key or several keys (possible ghosting): keep scanning.
                        row_nxt = rotate_row(row_r);
                    end
                end else begin
                    state_nxt = SCAN;
                end
            end
            DEBOUNCE: begin
                if (tick_s) begin
                    if (col_s_r == cap_col_r) begin
                        if (deb_inc_s == DEB_LAST) begin
                            key_code_nxt  = map_key(row_r, cap_col_r);
                            key_valid_nxt = 1'b1;
                            key_held_nxt  = 1'b1;
                            deb_cnt_nxt   = DEB_ZERO;
                            state_nxt     = HELD;
                        end else begin
                            deb_cnt_nxt = deb_inc_s;
                        end
                    end else begin
                        // Bounce: drop the candidate and resume at the next row.
                        deb_cnt_nxt = DEB_ZERO;
                        row_nxt     = rotate_row(row_r);
                        state_nxt   = SCAN;
                    end
                end else begin
                    state_nxt = DEBOUNCE;
                end
            end
            HELD: begin
                if (tick_s) begin
                    // Only an all-high column releases; a second key is ignored.
                    if (col_s_r == 4'b1111) begin
                        if (DEB_ONE == DEB_LAST) begin
                            key_held_nxt = 1'b0;
                            row_nxt      = 4'b1110;
                            rel_cnt_nxt  = DEB_ZERO;
                            state_nxt    = SCAN;
                        end else begin
                            rel_cnt_nxt = DEB_ONE;
                            state_nxt   = RELEASE;
                        end
                    end else begin
`ifdef AUTO_REPEAT_EN
                        // First repeat after REPEAT_DELAY ticks, then every REPEAT_RATE.
                        if (rep_inc_s == (rep_armed_r ? REP_RATE_L : REP_DELAY_L)) begin
                            key_valid_nxt = 1'b1;
                            rep_cnt_nxt   = REP_ZERO;
                            rep_armed_nxt = 1'b1;
                        end else begin
                            rep_cnt_nxt = rep_inc_s;
                        end
`else
                        state_nxt = HELD;
`endif
                    end
                end else begin
                    state_nxt = HELD;
                end
            end
            RELEASE: begin
                if (tick_s) begin
                    if (col_s_r == 4'b1111) begin
                        if (rel_inc_s == DEB_LAST) begin
                            key_held_nxt = 1'b0;
                            row_nxt      = 4'b1110;
                            rel_cnt_nxt  = DEB_ZERO;
                            state_nxt    = SCAN;
                        end else begin
                            rel_cnt_nxt = rel_inc_s;
                        end
                    end else begin
                        rel_cnt_nxt = DEB_ZERO;
                        state_nxt   = HELD;
                    end
                end else begin
                    state_nxt = RELEASE;
                end
            end
            default: begin
                state_nxt    = SCAN;
                row_nxt      = 4'b1110;
                deb_cnt_nxt  = DEB_ZERO;
                rel_cnt_nxt  = DEB_ZERO;
                key_held_nxt = 1'b0;
            end
        endcase
`ifdef AUTO_REPEAT_EN
        // Any exit from HELD restarts the repeat timing from zero.
        if (state_nxt != HELD) begin
            rep_cnt_nxt   = REP_ZERO;
            rep_armed_nxt = 1'b0;
        end else begin
            rep_armed_nxt = rep_armed_nxt;
        end
`endif
    end

    // State, counters, column synchroniser and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= SCAN;
            tick_cnt_r  <= '0;
            col_meta_r  <= 4'b1111;
            col_s_r     <= 4'b1111;
            row_r       <= 4'b1110;
            cap_col_r   <= 4'b1111;
            deb_cnt_r   <= '0;
            rel_cnt_r   <= '0;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt_r   <= '0;
            rep_armed_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt;
            tick_cnt_r  <= tick_s ? '0 : (tick_cnt_r + TICK_ONE);
            col_meta_r  <= column;
            col_s_r     <= col_meta_r;
            row_r       <= row_nxt;
            cap_col_r   <= cap_col_nxt;
            deb_cnt_r   <= deb_cnt_nxt;
            rel_cnt_r   <= rel_cnt_nxt;
            key_code_r  <= key_code_nxt;
            key_valid_r <= key_valid_nxt;
            key_held_r  <= key_held_nxt;
`ifdef AUTO_REPEAT_EN
            rep_cnt_r   <= rep_cnt_nxt;
            rep_armed_r <= rep_armed_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_module_barrido_teclado.sv
`timescale 1ns/1ps

module tb_module_barrido_teclado;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] column;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // Keypad model: 0 idle, 1 single switch (pr,pc), 2 ghost pattern on row 3.
    int mode = 0;
    int pr   = 0;
    int pc   = 0;

    int checks     = 0;
    int failures   = 0;
    int strobe_cnt = 0;
    logic prev_valid = 1'b0;
    logic [3:0] exp_q[$];

    logic [3:0] exp_map [16] = '{4'd1, 4'd2, 4'd3, 4'd10, 4'd4, 4'd5, 4'd6, 4'd11,
                                 4'd7, 4'd8, 4'd9, 4'd12, 4'd14, 4'd0, 4'd15, 4'd13};

    always #5 clk = ~clk;

    module_barrido_teclado #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .column    (column),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    function automatic logic [3:0] low_pat(input int i);
        logic [3:0] one;
        one = 4'b0001 << i;
        return ~one;
    endfunction

    always_comb begin
        column = 4'b1111;
        if (mode == 1 && row == low_pat(pr)) column = low_pat(pc);
        else if (mode == 2 && row == 4'b0111) column = 4'b1100;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe pops one expected code.
    always @(negedge clk) begin
        if (rst === 1'b1 && key_valid === 1'b1) begin
            strobe_cnt++;
            check("strobe_width", {31'd0, prev_valid}, 32'd0);
            check("held_at_strobe", {31'd0, key_held}, 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got code %0d expected no strobe", key_code);
            end else begin
                check("strobe_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
            end
        end
        prev_valid = key_valid;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_strobes(input int target, input int budget, input string name);
        int n = 0;
        while (strobe_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        check(name, strobe_cnt, target);
    endtask

    task automatic wait_held(input logic val, input int budget, input string name);
        int n = 0;
        while (key_held !== val && n < budget) begin
            step(1);
            n++;
        end
        check(name, {31'd0, key_held}, {31'd0, val});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row"},   {28'd0, row},      32'd14);
        check({tag, "_code"},  {28'd0, key_code}, 32'd0);
        check({tag, "_valid"}, {31'd0, key_valid}, 32'd0);
        check({tag, "_held"},  {31'd0, key_held},  32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int changes;
        logic [3:0] prev_row;

        // Reset
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        step(3);
        check("row_slot0", {28'd0, row}, 32'd14);
        step(1);
        check("row_slot1", {28'd0, row}, 32'd13);
        step(4);
        check("row_slot2", {28'd0, row}, 32'd11);
        step(4);
        check("row_slot3", {28'd0, row}, 32'd7);
        step(4);
        check("row_wrap", {28'd0, row}, 32'd14);

        // Clean press r1/c2
        base = strobe_cnt;
        exp_q.push_back(4'd6);
        pr = 1; pc = 2; mode = 1;
        step(40);
        check("clean_strobe_count", strobe_cnt, base + 1);
        check("clean_held", {31'd0, key_held}, 32'd1);
        mode = 0;
        step(8);
        check("held_after_release", {31'd0, key_held}, 32'd1);
        wait_held(1'b0, 20, "clean_held_fall");
        check("scan_restart_row", {28'd0, row}, 32'd14);
        check("code_kept", {28'd0, key_code}, 32'd6);

        // Bounce on r0/c0, aligned to the tick that just returned to SCAN
        base = strobe_cnt;
        pr = 0; pc = 0; mode = 1;
        step(8);
        mode = 0;
        step(4);
        check("bounce_no_strobe", strobe_cnt, base);
        exp_q.push_back(4'd1);
        mode = 1;
        wait_strobes(base + 1, 80, "bounce_strobe");
        mode = 0;
        wait_held(1'b0, 30, "bounce_release");

        // Ghosting: two columns low on row 3
        base = strobe_cnt;
        changes = 0;
        prev_row = row;
        mode = 2;
        repeat (40) begin
            step(1);
            if (row != prev_row) changes++;
            prev_row = row;
        end
        mode = 0;
        check("ghost_no_strobe", strobe_cnt, base);
        check("ghost_rotating", changes, 10);

        // Key map sweep
        for (int k = 0; k < 16; k++) begin
            base = strobe_cnt;
            exp_q.push_back(exp_map[k]);
            pr = k / 4; pc = k % 4; mode = 1;
            wait_strobes(base + 1, 60, "sweep_strobe");
            mode = 0;
            wait_held(1'b0, 30, "sweep_release");
        end

        // Reset while HELD on key 13
        base = strobe_cnt;
        exp_q.push_back(4'd13);
        pr = 3; pc = 3; mode = 1;
        wait_strobes(base + 1, 60, "prereset_strobe");
        step(6);
        check("held_before_reset", {31'd0, key_held}, 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        step(3);
        exp_q.push_back(4'd13);
        rst = 1'b1;
        wait_strobes(base + 2, 80, "postreset_strobe");
        mode = 0;
        wait_held(1'b0, 30, "postreset_release");

        step(2);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
